pendulum_sequencer: RTL and testbench
=====================================

PENDULUM_SEQUENCER -- requirements
Module: pendulum_sequencer

Interface
REQ-001 SHALL have parameter SIM_PERIOD, default 500_000, clock cycles per simulation tick (10 ms).
REQ-002 SHALL have parameter ADC_BITS, default 16, lever sample width (fixed point 14.2, signed).
REQ-003 SHALL have parameter CALIB_TIMEOUT, default 50_000_000, maximum cycles to wait for calib_done.
REQ-004 SHALL have port clock  in  1  single system clock; all state on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  request: calibrate, then run.
REQ-007 SHALL have port stop  in  1  request: return to IDLE.
REQ-008 SHALL have ports adc_req out 1, adc_ch out 1, adc_ack in 1, adc_data in ADC_BITS signed, forming the lever ADC handshake (adc_ch 0 = lever 1, 1 = lever 2).
REQ-009 SHALL have ports calib_start out 1 (pulse) and calib_done in 1 (level), forming the calibration handshake with the simulator.
REQ-010 SHALL have ports al1 out ADC_BITS signed and al2 out ADC_BITS signed, the committed lever values for the driver.
REQ-011 SHALL have port sim_tick out 1, a one-cycle pulse marking each simulation period boundary.
REQ-012 SHALL have ports busy out 1, calib_error out 1, overruns out 8 and state out 3 for debug.

Function
REQ-013 SHALL implement the states IDLE=0, CAL_START=1, CAL_WAIT=2, RUN=3 and ERROR=4, encoded on the state port.
REQ-014 SHALL move from IDLE to CAL_START on start=1, and stay in CAL_START for exactly one cycle with calib_start=1.
REQ-015 SHALL, in CAL_WAIT, move to RUN on the cycle after calib_done=1 is sampled, and move to ERROR with calib_error=1 after CALIB_TIMEOUT cycles without calib_done.
REQ-016 SHALL, in ERROR, hold calib_error=1 and move to CAL_START (clearing calib_error) on start=1.
REQ-017 SHALL, on stop=1, move to IDLE the next cycle from any state, clearing al1, al2, the period counter and any pending ADC request; stop SHALL win over a simultaneous start.
REQ-018 SHALL, in RUN, run a period counter 0..SIM_PERIOD-1 that starts at 0 on RUN entry and wraps, and assert sim_tick for exactly the cycle in which the counter equals SIM_PERIOD-1.
REQ-019 SHALL, at counter=0 in RUN, start a sample sequence: request channel 0, latch the value into shadow1, then request channel 1 and latch it into shadow2.
REQ-020 SHALL, when it raises adc_req, hold adc_req=1 with adc_ch stable until adc_ack=1, capture adc_data in that ack cycle, and drop adc_req the next cycle.
REQ-021 SHALL ignore adc_ack while adc_req=0.
REQ-022 SHALL, on the sim_tick cycle, update al1 and al2 atomically from shadow1/shadow2 if both samples of the current period completed.
REQ-023 SHALL otherwise keep the old al1/al2, increment overruns (saturating at 255), and abort the pending request, starting fresh at counter=0.
REQ-024 SHALL drive busy=1 in every state except IDLE and ERROR.
REQ-025 SHALL drive calib_start, sim_tick and adc_req to 0 outside the states named above.
REQ-026 SHALL clear overruns only on reset.

Reset
REQ-027 SHALL, while reset=0, immediately force state=IDLE, al1=al2=0, shadows=0, counter=0, and calib_start=sim_tick=adc_req=adc_ch=0.
REQ-028 SHALL, while reset=0, also force busy=0, calib_error=0 and overruns=0.
REQ-029 SHALL leave IDLE no earlier than the first clock edge after reset deasserts.

Verification
REQ-030 SHALL be verified, with SIM_PERIOD=100, by: start pulse, calib_done=1 three cycles after calib_start -> one calib_start pulse, RUN entered, sim_tick every 100 cycles.
REQ-031 SHALL be verified, with CALIB_TIMEOUT=50, by: calib_done held 0 -> ERROR with calib_error=1 exactly 50 cycles after CAL_WAIT entry; a following start -> CAL_START and calib_error=0.
REQ-032 SHALL be verified, in RUN, by: ADC acks after 2 cycles with values 0x0064 then 0xFF9C -> al1=100 and al2=-100, both changing in the same sim_tick cycle and unchanged before it.
REQ-033 SHALL be verified, in RUN, by: ADC never acks channel 1 -> al1/al2 unchanged at the tick, overruns incremented once per period, saturating at 255.
REQ-034 SHALL be verified by: start and stop asserted in the same cycle, and stop asserted mid-handshake -> IDLE, adc_req=0, al1=al2=0 next cycle.
REQ-035 SHALL be verified by: reset pulled low mid-RUN, asynchronous to clock -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/pendulum_sequencer_if.sv
// Lever ADC and calibration handshakes between the pendulum sequencer and the simulator side.
// master = sequencer, slave = ADC front-end / simulator.
interface pendulum_sequencer_if #(
  parameter int ADC_BITS = 16
);
  logic                       adc_req;
  logic                       adc_ch;
  logic                       adc_ack;
  logic signed [ADC_BITS-1:0] adc_data;
  logic                       calib_start;
  logic                       calib_done;

  modport master (
    output adc_req,
    output adc_ch,
    output calib_start,
    input  adc_ack,
    input  adc_data,
    input  calib_done
  );

  modport slave (
    input  adc_req,
    input  adc_ch,
    input  calib_start,
    output adc_ack,
    output adc_data,
    output calib_done
  );
endinterface

// File: rtl/pendulum_sequencer.sv
// Pendulum sequencer: calibrates the simulator, then samples both levers once per simulation
// period and commits them atomically to the driver on the period boundary.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start
// CAL_START | one-cycle calib_start pulse
// CAL_WAIT  | waiting for calib_done, bounded by CALIB_TIMEOUT
// RUN       | period counter running, lever sampling each period
// ERROR     | calibration timed out; start retries calibration
module pendulum_sequencer #(
  parameter int SIM_PERIOD    = 500_000,
  parameter int ADC_BITS      = 16,
  parameter int CALIB_TIMEOUT = 50_000_000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  pendulum_sequencer_if.master       bus,
  output logic signed [ADC_BITS-1:0] al1,
  output logic signed [ADC_BITS-1:0] al2,
  output logic                       sim_tick,
  output logic                       busy,
  output logic                       calib_error,
  output logic [7:0]                 overruns,
  output logic [2:0]                 state
);

  localparam int CNT_W = (SIM_PERIOD > 1) ? $clog2(SIM_PERIOD) : 1;
  localparam int TMR_W = (CALIB_TIMEOUT > 1) ? $clog2(CALIB_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIM_PERIOD - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CALIB_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CAL_START = 3'd1,
    ST_CAL_WAIT  = 3'd2,
    ST_RUN       = 3'd3,
    ST_ERROR     = 3'd4
  } state_t;

  // Per-period sample sequence; SEQ_GAP is the idle cycle between the two requests.
  typedef enum logic [2:0] {
    SEQ_IDLE = 3'd0,
    SEQ_CH0  = 3'd1,
    SEQ_GAP  = 3'd2,
    SEQ_CH1  = 3'd3,
    SEQ_DONE = 3'd4
  } seq_t;

  state_t state_q, state_d;
  seq_t   seq_q, seq_d;

  logic [CNT_W-1:0]          cnt_q;
  logic [TMR_W-1:0]          tmr_q;
  logic signed [ADC_BITS-1:0] shadow1_q, shadow2_q;
  logic signed [ADC_BITS-1:0] al1_q, al2_q;
  logic [7:0]                overruns_q;

  logic in_run;
  logic period_start;
  logic period_end;

  assign in_run       = (state_q == ST_RUN);
  assign period_start = in_run && (cnt_q == '0);
  assign period_end   = in_run && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:      if (start) state_d = ST_CAL_START;
        ST_CAL_START: state_d = ST_CAL_WAIT;
        ST_CAL_WAIT: begin
          if (bus.calib_done)     state_d = ST_RUN;
          else if (tmr_q == '0)   state_d = ST_ERROR;
        end
        ST_RUN:       state_d = ST_RUN;
        ST_ERROR:     if (start) state_d = ST_CAL_START;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // A period boundary always returns the sequence to idle, aborting any pending request.
  always_comb begin
    seq_d = seq_q;
    if (!in_run || stop || period_end) begin
      seq_d = SEQ_IDLE;
    end else if (period_start) begin
      seq_d = SEQ_CH0;
    end else begin
      case (seq_q)
        SEQ_CH0: if (bus.adc_ack) seq_d = SEQ_GAP;
        SEQ_GAP: seq_d = SEQ_CH1;
        SEQ_CH1: if (bus.adc_ack) seq_d = SEQ_DONE;
        default: seq_d = seq_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      seq_q      <= SEQ_IDLE;
      cnt_q      <= '0;
      tmr_q      <= '0;
      shadow1_q  <= '0;
      shadow2_q  <= '0;
      al1_q      <= '0;
      al2_q      <= '0;
      overruns_q <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;

      if (in_run && !stop && !period_end) cnt_q <= cnt_q + CNT_W'(1);
      else                                cnt_q <= '0;

      if (state_q == ST_CAL_START)                      tmr_q <= TMR_LOAD;
      else if (state_q == ST_CAL_WAIT && tmr_q != '0)   tmr_q <= tmr_q - TMR_W'(1);

      if (stop) begin
        shadow1_q <= '0;
        shadow2_q <= '0;
      end else begin
        if (seq_q == SEQ_CH0 && bus.adc_ack) shadow1_q <= bus.adc_data;
        if (seq_q == SEQ_CH1 && bus.adc_ack) shadow2_q <= bus.adc_data;
      end

      if (stop) begin
        al1_q <= '0;
        al2_q <= '0;
      end else if (period_end && seq_q == SEQ_DONE) begin
        al1_q <= shadow1_q;
        al2_q <= shadow2_q;
      end

      if (!stop && period_end && seq_q != SEQ_DONE && overruns_q != 8'hFF)
        overruns_q <= overruns_q + 8'd1;
    end
  end

  assign bus.calib_start = (state_q == ST_CAL_START);
  assign bus.adc_req     = (seq_q == SEQ_CH0) || (seq_q == SEQ_CH1);
  assign bus.adc_ch      = (seq_q == SEQ_CH1);

  assign sim_tick    = period_end;
  assign busy        = (state_q == ST_CAL_START) || (state_q == ST_CAL_WAIT) || in_run;
  assign calib_error = (state_q == ST_ERROR);
  assign overruns    = overruns_q;
  assign al1         = al1_q;
  assign al2         = al2_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pendulum_sequencer.sv
// Directed bench for pendulum_sequencer: calibration, timeout, lever sampling, overruns,
// stop handling and asynchronous reset.
module tb_pendulum_sequencer;

  localparam int SIM_PERIOD    = 100;
  localparam int ADC_BITS      = 16;
  localparam int CALIB_TIMEOUT = 50;

  logic clock;
  logic reset;
  logic start;
  logic stop;
  logic signed [ADC_BITS-1:0] al1, al2;
  logic sim_tick, busy, calib_error;
  logic [7:0] overruns;
  logic [2:0] state;

  pendulum_sequencer_if #(.ADC_BITS(ADC_BITS)) bus ();

  pendulum_sequencer #(
    .SIM_PERIOD    (SIM_PERIOD),
    .ADC_BITS      (ADC_BITS),
    .CALIB_TIMEOUT (CALIB_TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .bus         (bus),
    .al1         (al1),
    .al2         (al2),
    .sim_tick    (sim_tick),
    .busy        (busy),
    .calib_error (calib_error),
    .overruns    (overruns),
    .state       (state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ADC responder settings
  logic                       ack_en1 = 1'b1;
  logic signed [ADC_BITS-1:0] val0 = 16'sh0064;
  logic signed [ADC_BITS-1:0] val1 = 16'shFF9C;
  int                         wait_cnt = 0;

  // posedge monitor
  int cyc = 0;
  int n_cal_pulse = 0;
  int n_tick = 0;
  int last_tick_cyc = 0;
  int last_gap = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  always @(posedge clock) begin
    cyc++;
    if (bus.calib_start) n_cal_pulse++;
    if (sim_tick) begin
      n_tick++;
      last_gap      = cyc - last_tick_cyc;
      last_tick_cyc = cyc;
    end
  end

  // Acks each request two cycles after it rises; channel 1 acks can be suppressed.
  initial begin
    bus.adc_ack  = 1'b0;
    bus.adc_data = '0;
    forever begin
      @(negedge clock);
      bus.adc_ack = 1'b0;
      if (bus.adc_req) begin
        wait_cnt++;
        if (wait_cnt >= 2 && (!bus.adc_ch || ack_en1)) begin
          bus.adc_ack  = 1'b1;
          bus.adc_data = bus.adc_ch ? val1 : val0;
          wait_cnt     = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    reset          = 1'b0;
    start          = 1'b0;
    stop           = 1'b0;
    bus.calib_done = 1'b0;

    #2;
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_calib_start", bus.calib_start, 0);
    check("rst_adc_req", bus.adc_req, 0);
    check("rst_overruns", overruns, 0);

    step(2);
    reset = 1'b1;
    step(1);
    check("idle_hold", state, 0);

    // calibration then RUN with normal sampling
    start = 1'b1;
    step(1);
    check("cal_start_state", state, 1);
    check("cal_start_pulse", bus.calib_start, 1);
    start = 1'b0;
    step(1);
    check("cal_wait_state", state, 2);
    check("cal_start_drop", bus.calib_start, 0);
    step(2);
    bus.calib_done = 1'b1;
    step(1);
    check("run_entry", state, 3);
    check("run_busy", busy, 1);
    bus.calib_done = 1'b0;
    step(1);
    check("req_ch0", bus.adc_req, 1);
    check("ch0_sel", bus.adc_ch, 0);
    step(3);
    check("req_ch1", bus.adc_req, 1);
    check("ch1_sel", bus.adc_ch, 1);
    step(95);
    check("tick1", sim_tick, 1);
    check("al1_before", al1, 0);
    check("al2_before", al2, 0);
    step(1);
    check("tick1_drop", sim_tick, 0);
    check("al1_commit", al1, 100);
    check("al2_commit", al2, -100);
    check("no_overrun", overruns, 0);
    step(99);
    check("tick2", sim_tick, 1);
    step(1);
    check("tick_count", n_tick, 2);
    check("tick_gap", last_gap, 100);
    check("cal_pulses", n_cal_pulse, 1);

    // channel 1 never acked
    ack_en1 = 1'b0;
    val0    = 16'sh1234;
    step(99);
    check("stuck_req", bus.adc_req, 1);
    check("tick3", sim_tick, 1);
    step(1);
    check("overrun_1", overruns, 1);
    check("al1_kept", al1, 100);
    check("al2_kept", al2, -100);
    check("req_aborted", bus.adc_req, 0);
    step(1);
    check("req_restart", bus.adc_req, 1);
    check("restart_ch0", bus.adc_ch, 0);
    step(25399);
    check("overrun_255", overruns, 255);
    step(100);
    check("overrun_sat", overruns, 255);

    // stop mid-handshake
    step(5);
    check("mid_req", bus.adc_req, 1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("stop_state", state, 0);
    check("stop_req", bus.adc_req, 0);
    check("stop_al1", al1, 0);
    check("stop_al2", al2, 0);
    check("stop_busy", busy, 0);
    check("stop_keeps_ovr", overruns, 255);

    // calibration timeout
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    check("to_wait_entry", state, 2);
    step(49);
    check("to_wait_49", state, 2);
    check("to_err_49", calib_error, 0);
    step(1);
    check("to_error", state, 4);
    check("to_calib_error", calib_error, 1);
    check("to_busy", busy, 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("retry_state", state, 1);
    check("retry_err_clr", calib_error, 0);

    // stop wins over start
    step(1);
    stop = 1'b1;
    step(1);
    check("stop_from_wait", state, 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    check("stop_over_start", state, 0);
    check("stop_over_cal", bus.calib_start, 0);

    // asynchronous reset mid-RUN
    ack_en1 = 1'b1;
    val0    = 16'sh0064;
    start   = 1'b1;
    step(1);
    start          = 1'b0;
    bus.calib_done = 1'b1;
    step(2);
    bus.calib_done = 1'b0;
    check("rerun_entry", state, 3);
    step(100);
    check("rerun_al1", al1, 100);
    step(2);
    check("rerun_req", bus.adc_req, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_al1", al1, 0);
    check("arst_al2", al2, 0);
    check("arst_req", bus.adc_req, 0);
    check("arst_ch", bus.adc_ch, 0);
    check("arst_tick", sim_tick, 0);
    check("arst_busy", busy, 0);
    check("arst_err", calib_error, 0);
    check("arst_overruns", overruns, 0);
    step(2);
    reset = 1'b1;
    step(1);
    check("post_rst_idle", state, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
